// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and sequencer state encodings for alu_cmd_seq
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } seq_state_e;

    localparam int NUM_REGS = 4;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 4-entry register file, async reads, writeback-over-load write priority
module alu_regfile #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_en,
    input  logic [1:0]       wb_addr,
    input  logic [width-1:0] wb_data,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [width-1:0] wr_data,
    input  logic [1:0]       ra_addr,
    input  logic [1:0]       rb_addr,
    output logic [width-1:0] ra_data,
    output logic [width-1:0] rb_data
);
    import alu_pkg::*;

    logic [width-1:0] regs_q [NUM_REGS];
    logic [width-1:0] regs_d [NUM_REGS];

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];

    // Per-entry priority: the ALU writeback beats a direct load to the same
    // entry, while a load to a different entry still lands on the same edge.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wb_en && (wb_addr == 2'(i))) begin
                regs_d[i] = wb_data;
            end else if (wr_en && (wr_addr == 2'(i))) begin
                regs_d[i] = wr_data;
            end
        end
    end

    // Storage update with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - two-state command sequencer driving an external ALU
module alu_cmd_seq #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_dst,
    input  logic [1:0]       cmd_srca,
    input  logic [1:0]       cmd_srcb,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [width-1:0] wr_data,
    output logic [width-1:0] alu_a,
    output logic [width-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [width-1:0] alu_out,
    input  logic             alu_carry,
    output logic             res_valid,
    output logic [width-1:0] res_data,
    output logic             res_carry
);
    import alu_pkg::*;

    seq_state_e       state_q, state_d;
    logic             accept;
    logic             wb_en;
    logic [1:0]       dst_q;
    logic [width-1:0] ra_data, rb_data;
    logic [width-1:0] alu_a_q, alu_b_q;
    logic [1:0]       alu_sel_q;
    logic             res_valid_q, res_carry_q;
    logic [width-1:0] res_data_q;

    alu_regfile #(.width(width)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_en   (wb_en),
        .wb_addr (dst_q),
        .wb_data (alu_out),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ra_addr (cmd_srca),
        .rb_addr (cmd_srcb),
        .ra_data (ra_data),
        .rb_data (rb_data)
    );

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: EXEC always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake in IDLE, writeback strobe in EXEC.
    always_comb begin
        cmd_ready = 1'b0;
        wb_en     = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready = 1'b1;
            ST_EXEC: wb_en     = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    assign accept = cmd_ready && cmd_valid;

    // Operand capture on accept (SUB becomes ADD of the negated operand) and
    // result capture on writeback; everything else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= OP_AND;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            if (accept) begin
                dst_q   <= cmd_dst;
                alu_a_q <= ra_data;
                if (cmd_op == OP_SUB) begin
                    alu_b_q   <= ~rb_data + width'(1);
                    alu_sel_q <= OP_ADD;
                end else begin
                    alu_b_q   <= rb_data;
                    alu_sel_q <= cmd_op;
                end
            end
            if (wb_en) begin
                res_valid_q <= 1'b1;
                res_data_q  <= alu_out;
                res_carry_q <= alu_carry;
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb/tb_alu_cmd_seq.sv - scoreboard bench for alu_cmd_seq with a behavioural ALU
module tb_alu_cmd_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op, cmd_dst, cmd_srca, cmd_srcb;
    logic         wr_en;
    logic [1:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic [W-1:0] alu_a, alu_b;
    logic [1:0]   alu_sel;
    logic [W-1:0] alu_out;
    logic         alu_carry;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         res_carry;

    alu_cmd_seq #(.width(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_carry (res_carry)
    );

    always #5 clk = ~clk;

    // External ALU: 00 AND, 01 OR, 1x ADD with carry out.
    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        case (alu_sel)
            2'b00:   alu_out = alu_a & alu_b;
            2'b01:   alu_out = alu_a | alu_b;
            default: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
        endcase
    end

    typedef struct {
        logic [W-1:0] data;
        logic         carry;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   results_seen = 0;
    int   results_expected = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic c);
        exp_t e;
        e.data  = d;
        e.carry = c;
        exp_q.push_back(e);
        results_expected++;
    endtask

    // Monitor: every result pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            check("res_single_cycle", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0h/%0b required=none", res_data, res_carry);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_data", 32'(res_data), 32'(mon_e.data));
                check("res_carry", 32'(res_carry), 32'(mon_e.carry));
                results_seen++;
            end
        end
        prev_valid = res_valid;
    end

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Presents a command and returns 1 time unit after its accept edge.
    task automatic accept_cmd(input logic [1:0] op, input logic [1:0] dst,
                              input logic [1:0] a, input logic [1:0] b);
        @(negedge clk);
        wait_ready();
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_srca  = a;
        cmd_srcb  = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wb_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] addr, input logic [W-1:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] idx, input logic [W-1:0] exp_val);
        push(exp_val, 1'b0);
        accept_cmd(2'b00, idx, idx, idx);
        wb_edge();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    bit exp_rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);

        load(2'd1, 4'b0011);
        load(2'd2, 4'b0111);

        // ADD r0 = r1 + r2
        push(4'b1010, 1'b0);
        accept_cmd(2'b10, 2'd0, 2'd1, 2'd2);
        check("add_alu_b", 32'(alu_b), 32'b0111);
        check("add_alu_sel", 32'(alu_sel), 32'b10);
        wb_edge();
        read_reg(2'd0, 4'b1010);

        // SUB r3 = r2 - r1
        push(4'b0100, 1'b1);
        accept_cmd(2'b11, 2'd3, 2'd2, 2'd1);
        check("sub_alu_b", 32'(alu_b), 32'b1101);
        check("sub_alu_sel", 32'(alu_sel), 32'b10);
        check("sub_alu_a", 32'(alu_a), 32'b0111);
        wb_edge();
        check("sub_hold_alu_b", 32'(alu_b), 32'b1101);
        read_reg(2'd3, 4'b0100);

        // AND then OR
        push(4'b0011, 1'b0);
        accept_cmd(2'b00, 2'd3, 2'd1, 2'd2);
        wb_edge();
        push(4'b0111, 1'b0);
        accept_cmd(2'b01, 2'd3, 2'd1, 2'd2);
        wb_edge();

        // cmd_valid held for four cycles: two accepts of r0 = r1 + r1
        @(negedge clk);
        wait_ready();
        cmd_op = 2'b10; cmd_dst = 2'd0; cmd_srca = 2'd1; cmd_srcb = 2'd1;
        cmd_valid = 1'b1;
        push(4'b0110, 1'b0);
        push(4'b0110, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("ready_seq", 32'(cmd_ready), 32'(exp_rdy[k]));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        read_reg(2'd0, 4'b0110);

        // Direct load collides with writeback to r0: writeback wins
        push(4'b1010, 1'b0);
        accept_cmd(2'b10, 2'd0, 2'd1, 2'd2);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'b1111;
        wb_edge();
        wr_en = 1'b0;
        read_reg(2'd0, 4'b1010);

        // Reset during EXEC aborts the command
        accept_cmd(2'b10, 2'd3, 2'd1, 2'd2);
        rst_n = 1'b0;
        #1;
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_alu_b", 32'(alu_b), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_res_data", 32'(res_data), 32'd0);
        check("abort_res_carry", 32'(res_carry), 32'd0);
        read_reg(2'd0, 4'b0000);
        read_reg(2'd1, 4'b0000);
        read_reg(2'd3, 4'b0000);

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("results_count", 32'(results_seen), 32'(results_expected));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
